// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: shared UART receive/transmit types and defaults.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if: byte-side outputs of the UART receiver.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
);

  logic [DATA_BITS-1:0] o_DATA_OUT;
  logic                 o_DATA_VALID;
  logic                 o_FRAME_ERROR;
  logic                 o_BUSY;

  modport master (
    output o_DATA_OUT,
    output o_DATA_VALID,
    output o_FRAME_ERROR,
    output o_BUSY
  );

  modport slave (
    input o_DATA_OUT,
    input o_DATA_VALID,
    input o_FRAME_ERROR,
    input o_BUSY
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync: two-flop synchronizer for an asynchronous pin.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  wire logic i_CLK,
  input  wire logic i_RST,
  input  wire logic i_ASYNC,
  output logic      o_SYNC
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = i_ASYNC;
    sync_d = meta_q;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_SYNC = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver: oversampling 8N1 UART receiver with frame-error detection.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
  input  wire logic        i_CLK,
  input  wire logic        i_RST,
  input  wire logic        i_CLK_ENABLE,
  input  wire logic        i_RX,
  uart_receiver_if.master  rx_if
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  logic rx_s;

  rx_state_e             state_q,       state_d;
  logic [TICK_W-1:0]     tick_count_q,  tick_count_d;
  logic [BIT_W-1:0]      bit_count_q,   bit_count_d;
  logic [DATA_BITS-1:0]  shift_q,       shift_d;
  logic [DATA_BITS-1:0]  data_out_q,    data_out_d;
  logic                  data_valid_q,  data_valid_d;
  logic                  frame_error_q, frame_error_d;

  uart_rx_sync #(
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_ASYNC (i_RX),
    .o_SYNC  (rx_s)
  );

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q       <= ST_IDLE;
      tick_count_q  <= '0;
      bit_count_q   <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_count_q  <= tick_count_d;
      bit_count_q   <= bit_count_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Pulses default low every cycle so they last one clock regardless of tick rate.
  always_comb begin
    state_d       = state_q;
    tick_count_d  = tick_count_q;
    bit_count_d   = bit_count_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    if (i_CLK_ENABLE) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d      = ST_START;
            tick_count_d = '0;
          end
        end

        ST_START: begin
          if (tick_count_q == TICK_MID) begin
            if (!rx_s) begin
              state_d      = ST_DATA;
              tick_count_d = '0;
              bit_count_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_count_d = tick_count_q + TICK_ONE;
          end
        end

        ST_DATA: begin
          if (tick_count_q == TICK_LAST) begin
            shift_d      = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_count_d = '0;
            bit_count_d  = bit_count_q + BIT_ONE;
            if (bit_count_q == BIT_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            tick_count_d = tick_count_q + TICK_ONE;
          end
        end

        ST_STOP: begin
          if (tick_count_q == TICK_LAST) begin
            data_out_d   = shift_q;
            tick_count_d = '0;
            if (rx_s) begin
              data_valid_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              frame_error_d = 1'b1;
              state_d       = ST_WAIT_HIGH;
            end
          end else begin
            tick_count_d = tick_count_q + TICK_ONE;
          end
        end

        // A held-low (break) line must go high before a new start is accepted.
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign rx_if.o_DATA_OUT    = data_out_q;
  assign rx_if.o_DATA_VALID  = data_valid_q;
  assign rx_if.o_FRAME_ERROR = frame_error_q;
  assign rx_if.o_BUSY        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver: randomized self-checking bench for uart_receiver.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_receiver;

  localparam int OS    = 16;
  localparam int DBITS = 8;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic rx;

  int checks = 0;
  int errors = 0;

  int tick_div   = 1;
  int tick_phase = 0;
  int cycle_cnt  = 0;

  // Observed pulses, captured by the monitor.
  logic [DBITS-1:0] obs_data[$];
  bit               obs_err[$];
  int               obs_cyc[$];
  int               both_cnt = 0;
  int               wide_cnt = 0;
  logic             prev_valid = 1'b0;
  logic             prev_ferr  = 1'b0;

  // Reference model: every frame sent yields one pulse carrying its byte.
  logic [DBITS-1:0] exp_data[$];
  bit               exp_err[$];
  logic [DBITS-1:0] last_data = '0;

  uart_receiver_if #(.DATA_BITS(DBITS)) rx_if ();

  uart_receiver #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DBITS)
  ) dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_CLK_ENABLE (clk_en),
    .i_RX         (rx),
    .rx_if        (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    clk_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tick_phase = (tick_phase + 1) % tick_div;
      clk_en     = (tick_phase == 0);
    end
  end

  always @(negedge clk) begin
    if (rx_if.o_DATA_VALID || rx_if.o_FRAME_ERROR) begin
      obs_data.push_back(rx_if.o_DATA_OUT);
      obs_err.push_back(rx_if.o_FRAME_ERROR);
      obs_cyc.push_back(cycle_cnt);
    end
    if (rx_if.o_DATA_VALID && rx_if.o_FRAME_ERROR) both_cnt++;
    if ((rx_if.o_DATA_VALID && prev_valid) || (rx_if.o_FRAME_ERROR && prev_ferr)) wide_cnt++;
    prev_valid = rx_if.o_DATA_VALID;
    prev_ferr  = rx_if.o_FRAME_ERROR;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_err.delete();
    obs_cyc.delete();
    exp_data.delete();
    exp_err.delete();
  endtask

  // Drives one frame; the line is left at the stop-bit level.
  task automatic send_frame(input logic [DBITS-1:0] b, input bit stop_ok, input int cpb);
    rx = 1'b0;
    step(cpb);
    for (int i = 0; i < DBITS; i++) begin
      rx = b[i];
      step(cpb);
    end
    rx = stop_ok;
    step(cpb);
    exp_data.push_back(b);
    exp_err.push_back(!stop_ok);
    last_data = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    step(3);
    checks++; if (rx_if.o_DATA_OUT !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h want 00", rx_if.o_DATA_OUT); end
    checks++; if (rx_if.o_DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_if.o_DATA_VALID); end
    checks++; if (rx_if.o_FRAME_ERROR !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", rx_if.o_FRAME_ERROR); end
    checks++; if (rx_if.o_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_if.o_BUSY); end
    rst = 1'b0;
    step(5);
    checks++; if (rx_if.o_BUSY !== 1'b0 || obs_data.size() != 0) begin errors++; $display("FAIL post_reset_idle: busy %b pulses %0d want 0 0", rx_if.o_BUSY, obs_data.size()); end
  endtask

  task automatic test_clean_byte();
    int c0;
    clear_obs();
    c0 = cycle_cnt;
    send_frame(8'h0A, 1'b1, OS);
    step(20);
    checks++; if (obs_data.size() != 1) begin errors++; $display("FAIL clean_count: got %0d want 1", obs_data.size()); end
    if (obs_data.size() >= 1) begin
      checks++; if (obs_data[0] !== 8'h0A) begin errors++; $display("FAIL clean_data: got %0h want 0a", obs_data[0]); end
      checks++; if (obs_err[0] !== 1'b0) begin errors++; $display("FAIL clean_ferr: got %b want 0", obs_err[0]); end
      // 2 sync cycles + accept edge + 152 ticks to the stop sample.
      checks++; if (obs_cyc[0] - c0 != 2 + 1 + 152) begin errors++; $display("FAIL clean_latency: got %0d want %0d", obs_cyc[0] - c0, 155); end
    end
    checks++; if (rx_if.o_DATA_OUT !== 8'h0A || rx_if.o_BUSY !== 1'b0) begin errors++; $display("FAIL clean_hold: data %0h busy %b want 0a 0", rx_if.o_DATA_OUT, rx_if.o_BUSY); end
  endtask

  task automatic test_false_start();
    clear_obs();
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(2);
    checks++; if (rx_if.o_BUSY !== 1'b1) begin errors++; $display("FAIL false_start_busy: got %b want 1", rx_if.o_BUSY); end
    step(40);
    checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL false_start_pulse: got %0d want 0", obs_data.size()); end
    checks++; if (rx_if.o_BUSY !== 1'b0 || rx_if.o_DATA_OUT !== last_data) begin errors++; $display("FAIL false_start_idle: busy %b data %0h want 0 %0h", rx_if.o_BUSY, rx_if.o_DATA_OUT, last_data); end
  endtask

  task automatic test_frame_error();
    clear_obs();
    send_frame(8'h80, 1'b0, OS);
    step(40);
    checks++; if (rx_if.o_BUSY !== 1'b1) begin errors++; $display("FAIL ferr_busy_low: got %b want 1", rx_if.o_BUSY); end
    checks++; if (obs_data.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", obs_data.size()); end
    if (obs_data.size() >= 1) begin
      checks++; if (obs_err[0] !== 1'b1 || obs_data[0] !== 8'h80) begin errors++; $display("FAIL ferr_pulse: err %b data %0h want 1 80", obs_err[0], obs_data[0]); end
    end
    rx = 1'b1;
    step(6);
    checks++; if (rx_if.o_BUSY !== 1'b0) begin errors++; $display("FAIL ferr_release: busy %b want 0", rx_if.o_BUSY); end
    step(200);
    checks++; if (obs_data.size() != 1 || rx_if.o_BUSY !== 1'b0) begin errors++; $display("FAIL ferr_no_refire: pulses %0d busy %b want 1 0", obs_data.size(), rx_if.o_BUSY); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(8'h05, 1'b1, OS);
    send_frame(8'h10, 1'b1, OS);
    step(20);
    checks++; if (obs_data.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", obs_data.size()); end
    for (int i = 0; i < 2 && i < obs_data.size(); i++) begin
      checks++; if (obs_data[i] !== exp_data[i] || obs_err[i] !== 1'b0) begin errors++; $display("FAIL b2b_frame%0d: data %0h err %b want %0h 0", i, obs_data[i], obs_err[i], exp_data[i]); end
    end
  endtask

  task automatic test_sparse_tick();
    clear_obs();
    tick_div = 4;
    step(8);
    send_frame(8'h01, 1'b1, 4 * OS);
    step(80);
    tick_div = 1;
    step(4);
    checks++; if (obs_data.size() != 1) begin errors++; $display("FAIL sparse_count: got %0d want 1", obs_data.size()); end
    if (obs_data.size() >= 1) begin
      checks++; if (obs_data[0] !== 8'h01 || obs_err[0] !== 1'b0) begin errors++; $display("FAIL sparse_data: data %0h err %b want 01 0", obs_data[0], obs_err[0]); end
    end
    checks++; if (wide_cnt != 0) begin errors++; $display("FAIL sparse_width: wide pulses %0d want 0", wide_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_obs();
    rx = 1'b0;
    step(OS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      step(OS);
    end
    rx = 1'b1;
    step(OS / 2);
    rst = 1'b1;
    step(1);
    checks++; if (rx_if.o_BUSY !== 1'b0 || rx_if.o_DATA_OUT !== 8'h00) begin errors++; $display("FAIL mid_reset_state: busy %b data %0h want 0 00", rx_if.o_BUSY, rx_if.o_DATA_OUT); end
    rst = 1'b0;
    last_data = '0;
    step(20);
    checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL mid_reset_pulse: got %0d want 0", obs_data.size()); end
    send_frame(8'h3C, 1'b1, OS);
    step(20);
    checks++; if (obs_data.size() != 1) begin errors++; $display("FAIL mid_reset_count: got %0d want 1", obs_data.size()); end
    if (obs_data.size() >= 1) begin
      checks++; if (obs_data[0] !== 8'h3C || obs_err[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_data: data %0h err %b want 3c 0", obs_data[0], obs_err[0]); end
    end
  endtask

  task automatic test_random();
    logic [DBITS-1:0] b;
    bit               ok;
    int               gap;
    clear_obs();
    for (int n = 0; n < 24; n++) begin
      b   = DBITS'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 12);
      send_frame(b, ok, OS);
      if (!ok) begin
        step($urandom_range(0, 20));
        rx = 1'b1;
        step(3 + gap);
      end else begin
        step(gap);
      end
    end
    step(30);
    checks++; if (obs_data.size() != exp_data.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_data.size(), exp_data.size()); end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++; if (obs_data[i] !== exp_data[i] || obs_err[i] !== exp_err[i]) begin errors++; $display("FAIL rand_frame%0d: data %0h err %b want %0h %b", i, obs_data[i], obs_err[i], exp_data[i], exp_err[i]); end
    end
    checks++; if (both_cnt != 0 || wide_cnt != 0) begin errors++; $display("FAIL pulse_shape: overlap %0d wide %0d want 0 0", both_cnt, wide_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_clean_byte();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_sparse_tick();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
